// File: rtl/multi_resolver_pkg.sv
// Shared defaults and the registered per-slot record for the multi_resolver group pipeline.
package multi_resolver_pkg;

    localparam int unsigned DefWidth    = 2;
    localparam int unsigned DefRegW     = 6;
    localparam int unsigned DefMaxSpec  = 4;
    localparam int unsigned DefPayloadW = 96;
    localparam int unsigned DefTagW     = $clog2(DefMaxSpec + 1);

    // Field widths follow the package defaults; REG_W, MAX_SPEC and PAYLOAD_W must keep them.
    typedef struct packed {
        logic                   valid;
        logic [4:0]             rd;
        logic [DefRegW-1:0]     rs1;
        logic [DefRegW-1:0]     rs2;
        logic [DefRegW-1:0]     rn;
        logic [DefTagW-1:0]     tag;
        logic [DefPayloadW-1:0] payload;
    } slot_t;

endpackage

// File: rtl/multi_resolver_dep_bypass.sv
// Picks one source operand for slot SLOT: the youngest older in-group writer wins over the table.
module multi_resolver_dep_bypass #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned REG_W = 6,
    parameter int unsigned SLOT  = 0
) (
    input  logic [4:0]                  rs_i,
    input  logic [REG_W-1:0]            q_rs_i,
    input  logic [WIDTH-1:0]            needs_rn_i,
    input  logic [WIDTH-1:0][4:0]       rd_i,
    input  logic [WIDTH-1:0][REG_W-1:0] q_rn_i,
    output logic [REG_W-1:0]            src_o
);

    // Entries at or above SLOT are never consulted by this instance.
    logic unused_younger;
    assign unused_younger = ^{needs_rn_i, rd_i, q_rn_i};

    always_comb begin
        src_o = q_rs_i;
        for (int j = 0; j < int'(SLOT); j++) begin
            if (needs_rn_i[j] && (rd_i[j] == rs_i)) begin
                src_o = q_rn_i[j];
            end
        end
        if (rs_i == 5'd0) begin
            src_o = '0;
        end
    end

endmodule

// File: rtl/multi_resolver.sv
// Resolves an instruction group in one cycle: source bypass, rename capture and jump tagging,
// with a single output register and an unresolved-jump depth counter.
module multi_resolver
    import multi_resolver_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned REG_W     = DefRegW,
    parameter int unsigned MAX_SPEC  = DefMaxSpec,
    parameter int unsigned PAYLOAD_W = DefPayloadW,
    localparam int unsigned TAG_W    = $clog2(MAX_SPEC + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_slot_valid,
    input  logic [WIDTH-1:0]              in_writes,
    input  logic [WIDTH-1:0]              in_jumps,
    input  logic [WIDTH-1:0][4:0]         in_rd,
    input  logic [WIDTH-1:0][4:0]         in_rs1,
    input  logic [WIDTH-1:0][4:0]         in_rs2,
    input  logic [WIDTH-1:0][PAYLOAD_W-1:0] in_payload,
    input  logic [WIDTH-1:0][REG_W-1:0]   q_rs1,
    input  logic [WIDTH-1:0][REG_W-1:0]   q_rs2,
    input  logic [WIDTH-1:0][REG_W-1:0]   q_rn,
    output logic [WIDTH-1:0]              rn_consume,
    input  logic                          br_resolve,
    input  logic                          br_mispredict,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_slot_valid,
    output logic [WIDTH-1:0][REG_W-1:0]   out_rs1,
    output logic [WIDTH-1:0][REG_W-1:0]   out_rs2,
    output logic [WIDTH-1:0][REG_W-1:0]   out_rn,
    output logic [WIDTH-1:0][4:0]         out_rd,
    output logic [WIDTH-1:0][TAG_W-1:0]   out_tag,
    output logic [WIDTH-1:0][PAYLOAD_W-1:0] out_payload,
    output logic [TAG_W-1:0]              spec_depth,
    output logic                          err_underflow
);

    logic                          flush, reg_stall, spec_stall, fire, dec, underflow;
    logic [WIDTH-1:0]              needs_rn;
    logic [WIDTH-1:0][REG_W-1:0]   src1, src2;
    int unsigned                   jcnt, depth_ext;
    int unsigned                   jpre [WIDTH];
    logic                          out_valid_q, out_valid_d;
    logic [TAG_W-1:0]              spec_depth_q, spec_depth_d;
    logic                          err_underflow_q, err_underflow_d;
    slot_t                         slot_q [WIDTH];
    slot_t                         slot_d [WIDTH];

    assign depth_ext = 32'(spec_depth_q);

    always_comb begin
        jcnt      = 0;
        reg_stall = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            needs_rn[i] = in_slot_valid[i] & in_writes[i] & (in_rd[i] != 5'd0);
            if (needs_rn[i] && (q_rn[i] == '0)) begin
                reg_stall = 1'b1;
            end
            jpre[i] = jcnt;
            if (in_slot_valid[i] && in_jumps[i]) begin
                jcnt = jcnt + 1;
            end
        end
    end

    assign flush      = br_resolve & br_mispredict;
    assign spec_stall = (depth_ext + jcnt) > MAX_SPEC;
    assign in_ready   = ~reset & (~out_valid_q | out_ready) & ~reg_stall & ~spec_stall & ~flush;
    assign fire       = in_valid & in_ready;
    assign rn_consume = fire ? needs_rn : '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slot
        multi_resolver_dep_bypass #(
            .WIDTH (WIDTH),
            .REG_W (REG_W),
            .SLOT  (i)
        ) u_bypass_rs1 (
            .rs_i       (in_rs1[i]),
            .q_rs_i     (q_rs1[i]),
            .needs_rn_i (needs_rn),
            .rd_i       (in_rd),
            .q_rn_i     (q_rn),
            .src_o      (src1[i])
        );
        multi_resolver_dep_bypass #(
            .WIDTH (WIDTH),
            .REG_W (REG_W),
            .SLOT  (i)
        ) u_bypass_rs2 (
            .rs_i       (in_rs2[i]),
            .q_rs_i     (q_rs2[i]),
            .needs_rn_i (needs_rn),
            .rd_i       (in_rd),
            .q_rn_i     (q_rn),
            .src_o      (src2[i])
        );
    end

    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            slot_d[i].valid   = in_slot_valid[i];
            slot_d[i].rd      = in_rd[i];
            slot_d[i].rs1     = src1[i];
            slot_d[i].rs2     = src2[i];
            slot_d[i].rn      = needs_rn[i] ? q_rn[i] : '0;
            slot_d[i].tag     = TAG_W'(depth_ext + jpre[i]);
            slot_d[i].payload = in_payload[i];
        end
    end

    always_comb begin
        underflow       = br_resolve & ~br_mispredict & (spec_depth_q == '0);
        dec             = br_resolve & ~br_mispredict & (spec_depth_q != '0);
        out_valid_d     = out_valid_q;
        spec_depth_d    = TAG_W'(depth_ext + (fire ? jcnt : 32'd0) - 32'(dec));
        err_underflow_d = err_underflow_q | underflow;
        if (flush) begin
            out_valid_d  = 1'b0;
            spec_depth_d = '0;
        end else if (fire) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q     <= 1'b0;
            spec_depth_q    <= '0;
            err_underflow_q <= 1'b0;
            slot_q          <= '{default: '0};
        end else begin
            out_valid_q     <= out_valid_d;
            spec_depth_q    <= spec_depth_d;
            err_underflow_q <= err_underflow_d;
            if (fire) begin
                slot_q <= slot_d;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            out_slot_valid[i] = slot_q[i].valid;
            out_rd[i]         = slot_q[i].rd;
            out_rs1[i]        = slot_q[i].rs1;
            out_rs2[i]        = slot_q[i].rs2;
            out_rn[i]         = slot_q[i].rn;
            out_tag[i]        = slot_q[i].tag;
            out_payload[i]    = slot_q[i].payload;
        end
    end

    assign out_valid     = out_valid_q;
    assign spec_depth    = spec_depth_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_multi_resolver.sv
// Directed scenarios plus randomized traffic against a behavioural group-resolution model.
module tb_multi_resolver;

    localparam int unsigned W  = 4;
    localparam int unsigned RW = 6;
    localparam int unsigned MS = 4;
    localparam int unsigned PW = 96;
    localparam int unsigned TW = 3;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  in_valid, in_ready;
    logic [W-1:0]          in_slot_valid, in_writes, in_jumps;
    logic [W-1:0][4:0]     in_rd, in_rs1, in_rs2;
    logic [W-1:0][PW-1:0]  in_payload;
    logic [W-1:0][RW-1:0]  q_rs1, q_rs2, q_rn;
    logic [W-1:0]          rn_consume;
    logic                  br_resolve, br_mispredict, out_valid, out_ready;
    logic [W-1:0]          out_slot_valid;
    logic [W-1:0][RW-1:0]  out_rs1, out_rs2, out_rn;
    logic [W-1:0][4:0]     out_rd;
    logic [W-1:0][TW-1:0]  out_tag;
    logic [W-1:0][PW-1:0]  out_payload;
    logic [TW-1:0]         spec_depth;
    logic                  err_underflow;

    int errors = 0;
    int checks = 0;

    // Reference state: the group currently held downstream plus depth and sticky error.
    bit              m_valid = 1'b0;
    int              m_depth = 0;
    bit              m_err   = 1'b0;
    logic [W-1:0]    m_sv;
    logic [4:0]      m_rd  [W];
    logic [RW-1:0]   m_rs1 [W];
    logic [RW-1:0]   m_rs2 [W];
    logic [RW-1:0]   m_rn  [W];
    int              m_tag [W];
    logic [PW-1:0]   m_pay [W];

    always #5 clock = ~clock;

    multi_resolver #(
        .WIDTH     (W),
        .REG_W     (RW),
        .MAX_SPEC  (MS),
        .PAYLOAD_W (PW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_slot_valid  (in_slot_valid),
        .in_writes      (in_writes),
        .in_jumps       (in_jumps),
        .in_rd          (in_rd),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_payload     (in_payload),
        .q_rs1          (q_rs1),
        .q_rs2          (q_rs2),
        .q_rn           (q_rn),
        .rn_consume     (rn_consume),
        .br_resolve     (br_resolve),
        .br_mispredict  (br_mispredict),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_slot_valid (out_slot_valid),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_rn         (out_rn),
        .out_rd         (out_rd),
        .out_tag        (out_tag),
        .out_payload    (out_payload),
        .spec_depth     (spec_depth),
        .err_underflow  (err_underflow)
    );

    function automatic bit needs(int i);
        return in_slot_valid[i] && in_writes[i] && (in_rd[i] != 5'd0);
    endfunction

    function automatic int jumps_before(int i);
        int n = 0;
        for (int j = 0; j < i; j++) if (in_slot_valid[j] && in_jumps[j]) n++;
        return n;
    endfunction

    function automatic bit exp_ready();
        if (reset) return 1'b0;
        if (br_resolve && br_mispredict) return 1'b0;
        if (m_valid && !out_ready) return 1'b0;
        for (int i = 0; i < W; i++) if (needs(i) && q_rn[i] == '0) return 1'b0;
        if (m_depth + jumps_before(W) > MS) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] exp_consume();
        logic [W-1:0] c = '0;
        if (in_valid && exp_ready()) for (int i = 0; i < W; i++) c[i] = needs(i);
        return c;
    endfunction

    // Nearest older writer of the same register supplies the value.
    function automatic logic [RW-1:0] resolve_src(int i, logic [4:0] rs, logic [RW-1:0] qrs);
        if (rs == 5'd0) return '0;
        for (int j = i - 1; j >= 0; j--) if (needs(j) && in_rd[j] == rs) return q_rn[j];
        return qrs;
    endfunction

    task automatic tick();
        bit fire;
        int pre;
        fire = in_valid && exp_ready();
        pre  = m_depth;
        @(posedge clock);
        if (reset) begin
            m_valid = 1'b0; m_depth = 0; m_err = 1'b0;
        end else if (br_resolve && br_mispredict) begin
            m_valid = 1'b0; m_depth = 0;
        end else begin
            if (fire) begin
                m_valid = 1'b1;
                for (int i = 0; i < W; i++) begin
                    m_sv[i]  = in_slot_valid[i];
                    m_rd[i]  = in_rd[i];
                    m_rs1[i] = resolve_src(i, in_rs1[i], q_rs1[i]);
                    m_rs2[i] = resolve_src(i, in_rs2[i], q_rs2[i]);
                    m_rn[i]  = needs(i) ? q_rn[i] : '0;
                    m_tag[i] = pre + jumps_before(i);
                    m_pay[i] = in_payload[i];
                end
                m_depth = m_depth + jumps_before(W);
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (br_resolve) begin
                if (pre > 0) m_depth = m_depth - 1;
                else m_err = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; in_valid = 1'b0; in_slot_valid = '0; in_writes = '0; in_jumps = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_payload = '0;
        q_rs1 = '0; q_rs2 = '0; q_rn = '0;
        br_resolve = 1'b0; br_mispredict = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; in_valid = 1'b1; in_slot_valid = 4'b0001; in_writes = 4'b0001;
        in_rd[0] = 5'd4; q_rn[0] = 6'd9;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (rn_consume !== 4'b0) begin errors++; $display("FAIL reset_consume: got %b want 0000", rn_consume); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (spec_depth !== 3'd0) begin errors++; $display("FAIL reset_depth: got %0d want 0", spec_depth); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_underflow); end
        checks++; if (out_rn !== '0 || out_slot_valid !== 4'b0) begin
            errors++; $display("FAIL reset_data: got rn=%h sv=%b want 0", out_rn, out_slot_valid);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_bypass_w2();
        idle_inputs();
        in_valid = 1'b1; in_slot_valid = 4'b0011; in_writes = 4'b0001;
        in_rd[0] = 5'd5; q_rn[0] = 6'd33; in_rs1[1] = 5'd5; in_rs2[1] = 5'd0;
        q_rs1[1] = 6'd9; q_rs2[1] = 6'd17;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bypass2_ready: got %b want 1", in_ready); end
        checks++; if (rn_consume !== 4'b0001) begin errors++; $display("FAIL bypass2_consume: got %b want 0001", rn_consume); end
        tick();
        idle_inputs();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass2_valid: got %b want 1", out_valid); end
        checks++; if (out_rs1[1] !== 6'd33) begin errors++; $display("FAIL bypass2_rs1: got %0d want 33", out_rs1[1]); end
        checks++; if (out_rs2[1] !== 6'd0) begin errors++; $display("FAIL bypass2_rs2: got %0d want 0", out_rs2[1]); end
        checks++; if (out_rn[0] !== 6'd33 || out_rn[1] !== 6'd0) begin
            errors++; $display("FAIL bypass2_rn: got %0d,%0d want 33,0", out_rn[0], out_rn[1]);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_bypass_w4();
        idle_inputs();
        in_valid = 1'b1; in_slot_valid = 4'b1111; in_writes = 4'b0101;
        in_rd[0] = 5'd7; in_rd[2] = 5'd7; q_rn[0] = 6'd40; q_rn[2] = 6'd41;
        in_rs1[2] = 5'd7; in_rs1[3] = 5'd7; q_rs1[3] = 6'd3; q_rs1[2] = 6'd2;
        #1;
        checks++; if (rn_consume !== 4'b0101) begin errors++; $display("FAIL bypass4_consume: got %b want 0101", rn_consume); end
        tick();
        idle_inputs();
        checks++; if (out_rs1[3] !== 6'd41) begin errors++; $display("FAIL bypass4_rs1_3: got %0d want 41", out_rs1[3]); end
        checks++; if (out_rs1[2] !== 6'd40) begin errors++; $display("FAIL bypass4_rs1_2: got %0d want 40", out_rs1[2]); end
        tick();
    endtask

    task automatic test_reg_stall();
        idle_inputs();
        in_valid = 1'b1; in_slot_valid = 4'b0011; in_writes = 4'b0010; in_rd[1] = 5'd3; q_rn[1] = 6'd0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", in_ready); end
        checks++; if (rn_consume !== 4'b0) begin errors++; $display("FAIL stall_consume: got %b want 0000", rn_consume); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid: got %b want 0", out_valid); end
        q_rn[1] = 6'd12;
        #1;
        checks++; if (rn_consume !== 4'b0010) begin errors++; $display("FAIL unstall_consume: got %b want 0010", rn_consume); end
        tick();
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || out_rn[1] !== 6'd12) begin
            errors++; $display("FAIL unstall_rn: got v=%b rn=%0d want v=1 rn=12", out_valid, out_rn[1]);
        end
        tick();
    endtask

    task automatic test_spec_depth();
        idle_inputs();
        in_valid = 1'b1; in_slot_valid = 4'b0111; in_jumps = 4'b0111;
        tick();
        checks++; if (spec_depth !== 3'd3) begin errors++; $display("FAIL spec_fill: got %0d want 3", spec_depth); end
        checks++; if (out_tag[2] !== 3'd2) begin errors++; $display("FAIL spec_tag_first: got %0d want 2", out_tag[2]); end
        in_slot_valid = 4'b0011; in_jumps = 4'b0011; in_payload[0] = 96'h5EED_CAFE;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL spec_stall: got %b want 0", in_ready); end
        tick();
        br_resolve = 1'b1;
        tick();
        checks++; if (spec_depth !== 3'd2) begin errors++; $display("FAIL spec_resolve: got %0d want 2", spec_depth); end
        br_resolve = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL spec_unstall: got %b want 1", in_ready); end
        tick();
        checks++; if (spec_depth !== 3'd4) begin errors++; $display("FAIL spec_after: got %0d want 4", spec_depth); end
        checks++; if (out_tag[0] !== 3'd2 || out_tag[1] !== 3'd3) begin
            errors++; $display("FAIL spec_tags: got %0d,%0d want 2,3", out_tag[0], out_tag[1]);
        end
    endtask

    task automatic test_hold_flush();
        idle_inputs();
        out_ready = 1'b0; in_valid = 1'b1; in_slot_valid = 4'b0001; in_writes = 4'b0001;
        in_rd[0] = 5'd2; q_rn[0] = 6'd5;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b want 0", in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_tag[1] !== 3'd3 || out_payload[0] !== 96'h5EED_CAFE) begin
                errors++; $display("FAIL hold_stable: got v=%b tag=%0d pay=%h want v=1 tag=3 pay=5eedcafe",
                                   out_valid, out_tag[1], out_payload[0]);
            end
        end
        br_resolve = 1'b1; br_mispredict = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || rn_consume !== 4'b0) begin
            errors++; $display("FAIL flush_block: got rdy=%b cons=%b want 0,0000", in_ready, rn_consume);
        end
        tick();
        checks++; if (out_valid !== 1'b0 || spec_depth !== 3'd0) begin
            errors++; $display("FAIL flush_state: got v=%b depth=%0d want 0,0", out_valid, spec_depth);
        end
        idle_inputs();
    endtask

    task automatic test_bubble();
        idle_inputs();
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_slot_valid !== 4'b0) begin
            errors++; $display("FAIL bubble_out: got v=%b sv=%b want 1,0000", out_valid, out_slot_valid);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_hold();
        idle_inputs();
        in_valid = 1'b1; in_slot_valid = 4'b0001; in_writes = 4'b0001; in_rd[0] = 5'd6; q_rn[0] = 6'd20;
        tick();
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (rn_consume !== 4'b0) begin errors++; $display("FAIL rsthold_consume: got %b want 0000", rn_consume); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_rn[0] !== 6'd0) begin
            errors++; $display("FAIL rsthold_out: got v=%b rn=%0d want 0,0", out_valid, out_rn[0]);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_underflow();
        idle_inputs();
        br_resolve = 1'b1;
        tick();
        checks++; if (err_underflow !== 1'b1 || spec_depth !== 3'd0) begin
            errors++; $display("FAIL underflow_set: got err=%b depth=%0d want 1,0", err_underflow, spec_depth);
        end
        br_resolve = 1'b0;
        tick();
        tick();
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b want 1", err_underflow); end
        reset = 1'b1;
        tick();
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b want 0", err_underflow); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            reset         = ($urandom_range(0, 99) == 0);
            in_valid      = ($urandom_range(0, 3) != 0);
            in_slot_valid = W'($urandom);
            in_writes     = W'($urandom);
            br_resolve    = ($urandom_range(0, 4) == 0);
            br_mispredict = br_resolve && ($urandom_range(0, 3) == 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < W; i++) begin
                in_jumps[i]   = ($urandom_range(0, 4) == 0);
                in_rd[i]      = 5'($urandom_range(0, 7));
                in_rs1[i]     = 5'($urandom_range(0, 7));
                in_rs2[i]     = 5'($urandom_range(0, 7));
                q_rs1[i]      = RW'($urandom);
                q_rs2[i]      = RW'($urandom);
                q_rn[i]       = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom_range(1, 63));
                in_payload[i] = {$urandom, $urandom, $urandom};
            end
            #1;
            checks++; if (in_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, exp_ready());
            end
            checks++; if (rn_consume !== exp_consume()) begin
                errors++; $display("FAIL rand_consume[%0d]: got %b want %b", n, rn_consume, exp_consume());
            end
            tick();
            checks++; if (out_valid !== m_valid || spec_depth !== TW'(m_depth) || err_underflow !== m_err) begin
                errors++; $display("FAIL rand_state[%0d]: got v=%b d=%0d e=%b want v=%b d=%0d e=%b", n,
                                   out_valid, spec_depth, err_underflow, m_valid, m_depth, m_err);
            end
            if (m_valid) begin
                for (int i = 0; i < W; i++) begin
                    checks++;
                    if (out_slot_valid[i] !== m_sv[i] || out_rd[i] !== m_rd[i] || out_rs1[i] !== m_rs1[i] ||
                        out_rs2[i] !== m_rs2[i] || out_rn[i] !== m_rn[i] || out_tag[i] !== TW'(m_tag[i]) ||
                        out_payload[i] !== m_pay[i]) begin
                        errors++;
                        $display("FAIL rand_slot[%0d][%0d]: got sv=%b rd=%0d s1=%0d s2=%0d rn=%0d tag=%0d want sv=%b rd=%0d s1=%0d s2=%0d rn=%0d tag=%0d",
                                 n, i, out_slot_valid[i], out_rd[i], out_rs1[i], out_rs2[i], out_rn[i], out_tag[i],
                                 m_sv[i], m_rd[i], m_rs1[i], m_rs2[i], m_rn[i], m_tag[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass_w2();
        test_bypass_w4();
        test_reg_stall();
        test_spec_depth();
        test_hold_flush();
        test_bubble();
        test_reset_mid_hold();
        test_underflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
